// File: rtl/pio_in_capture.sv
// pio_in_capture: fabric-side input PIO read back by the HPS over the
// lightweight bridge. Synchronizes external inputs, optionally debounces
// them, captures configured edges into sticky flags and raises a level
// interrupt. Avalon-MM agent with a fixed read latency of one clock.
//
// Optional feature: define PIO_IN_DEBOUNCE_EN to insert a per-bit
// debounce counter of DEBOUNCE_CYCLES stable clocks between the
// synchronizer and the accepted level. Without it, the accepted level
// simply follows the synchronizer one clock later.
//
// Parameters:
//   WIDTH            number of input bits (1..16)
//   DEBOUNCE_CYCLES  clocks a new level must persist (>=2, debounce only)
// Ports:
//   clk_clk            single clock, rising edge
//   reset_reset        asynchronous active-high reset
//   avs_address        word address (0 DATA, 1 MASK, 2 CAPTURE, 3 EDGECFG)
//   avs_read           read strobe
//   avs_write          write strobe
//   avs_writedata      write data
//   avs_readdata       read data, valid with avs_readdatavalid
//   avs_readdatavalid  one-clock pulse one clock after an accepted read
//   avs_waitrequest    always 0
//   pio_in             asynchronous external inputs
//   irq                registered level interrupt

module pio_in_capture #(
   parameter int WIDTH           = 2,
   parameter int DEBOUNCE_CYCLES = 1000
) (
   input  logic             clk_clk,
   input  logic             reset_reset,
   input  logic [1:0]       avs_address,
   input  logic             avs_read,
   input  logic             avs_write,
   input  logic [31:0]      avs_writedata,
   output logic [31:0]      avs_readdata,
   output logic             avs_readdatavalid,
   output logic             avs_waitrequest,
   input  logic [WIDTH-1:0] pio_in,
   output logic             irq
);

   localparam logic [1:0] ADDR_DATA    = 2'd0;
   localparam logic [1:0] ADDR_MASK    = 2'd1;
   localparam logic [1:0] ADDR_CAPTURE = 2'd2;
   localparam logic [1:0] ADDR_EDGECFG = 2'd3;

   // Input path
   logic [WIDTH-1:0] meta;
   logic [WIDTH-1:0] sync;
   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] stable_q;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;

   // Register file
   logic [WIDTH-1:0] mask;
   logic [WIDTH-1:0] capture;
   logic [WIDTH-1:0] rise_en;
   logic [WIDTH-1:0] fall_en;

   // Next-state terms
   logic             wr_mask;
   logic             wr_capture;
   logic             wr_edgecfg;
   logic [WIDTH-1:0] mask_next;
   logic [WIDTH-1:0] cap_set;
   logic [WIDTH-1:0] cap_clr;
   logic [WIDTH-1:0] capture_next;
   logic [31:0]      rd_word;

   // Only the low WIDTH bits of each field are decoded.
   logic             unused_wdata;
   assign unused_wdata = ^avs_writedata;

   assign avs_waitrequest = 1'b0;

   // Two-flop synchronizer per bit
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         meta <= '0;
         sync <= '0;
      end else begin
         meta <= pio_in;
         sync <= meta;
      end
   end

`ifdef PIO_IN_DEBOUNCE_EN
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [CNT_W-1:0] count [WIDTH];

   // A differing synchronized level must persist for DEBOUNCE_CYCLES
   // consecutive clocks; any return to the accepted level restarts it.
   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         stable <= '0;
         for (int i = 0; i < WIDTH; i++) begin
            count[i] <= '0;
         end
      end else begin
         for (int i = 0; i < WIDTH; i++) begin
            if (sync[i] == stable[i]) begin
               count[i] <= '0;
            end else if (count[i] == CNT_LAST) begin
               stable[i] <= sync[i];
               count[i]  <= '0;
            end else begin
               count[i] <= count[i] + CNT_W'(1);
            end
         end
      end
   end
`else
   localparam int unused_debounce = DEBOUNCE_CYCLES;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         stable <= '0;
      end else begin
         stable <= sync;
      end
   end
`endif

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         stable_q <= '0;
      end else begin
         stable_q <= stable;
      end
   end

   assign rise = stable & ~stable_q;
   assign fall = ~stable & stable_q;

   // Write decode
   assign wr_mask    = avs_write && (avs_address == ADDR_MASK);
   assign wr_capture = avs_write && (avs_address == ADDR_CAPTURE);
   assign wr_edgecfg = avs_write && (avs_address == ADDR_EDGECFG);

   assign mask_next = wr_mask ? avs_writedata[WIDTH-1:0] : mask;
   assign cap_set   = (rise & rise_en) | (fall & fall_en);
   assign cap_clr   = wr_capture ? avs_writedata[WIDTH-1:0] : '0;

   // Clear first, then set: a new edge wins over a same-cycle W1C.
   assign capture_next = (capture & ~cap_clr) | cap_set;

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         mask    <= '0;
         capture <= '0;
         rise_en <= '0;
         fall_en <= '0;
         irq     <= 1'b0;
      end else begin
         mask    <= mask_next;
         capture <= capture_next;
         if (wr_edgecfg) begin
            rise_en <= avs_writedata[WIDTH-1:0];
            fall_en <= avs_writedata[16 +: WIDTH];
         end
         // Uses the post-write mask and capture so irq tracks them
         // with exactly one clock of delay.
         irq <= |(capture_next & mask_next);
      end
   end

   // Read mux sees pre-write register values.
   always_comb begin
      rd_word = '0;
      case (avs_address)
         ADDR_DATA:    rd_word[WIDTH-1:0] = stable;
         ADDR_MASK:    rd_word[WIDTH-1:0] = mask;
         ADDR_CAPTURE: rd_word[WIDTH-1:0] = capture;
         ADDR_EDGECFG: begin
            rd_word[WIDTH-1:0]  = rise_en;
            rd_word[16 +: WIDTH] = fall_en;
         end
         default:      rd_word = '0;
      endcase
   end

   always_ff @(posedge clk_clk or posedge reset_reset) begin
      if (reset_reset) begin
         avs_readdata      <= '0;
         avs_readdatavalid <= 1'b0;
      end else begin
         avs_readdatavalid <= avs_read;
         if (avs_read) begin
            avs_readdata <= rd_word;
         end
      end
   end

endmodule

// File: tb/tb_pio_in_capture.sv
// tb_pio_in_capture: directed scenarios plus randomized traffic, checked
// by a scoreboard fed from a behavioural reference model.

module tb_pio_in_capture;

   localparam int W = 3;
   localparam int D = 8;
`ifdef PIO_IN_DEBOUNCE_EN
   localparam int LAT = 2 + D;
`else
   localparam int LAT = 3;
`endif
   localparam int HN = D + 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic [1:0]    avs_address = '0;
   logic          avs_read = 1'b0;
   logic          avs_write = 1'b0;
   logic [31:0]   avs_writedata = '0;
   logic [31:0]   avs_readdata;
   logic          avs_readdatavalid;
   logic          avs_waitrequest;
   logic [W-1:0]  pio_in = '0;
   logic          irq;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   pio_in_capture #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
      .clk_clk           (clk),
      .reset_reset       (rst),
      .avs_address       (avs_address),
      .avs_read          (avs_read),
      .avs_write         (avs_write),
      .avs_writedata     (avs_writedata),
      .avs_readdata      (avs_readdata),
      .avs_readdatavalid (avs_readdatavalid),
      .avs_waitrequest   (avs_waitrequest),
      .pio_in            (pio_in),
      .irq               (irq)
   );

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t",
                  nm, act, exp, $time);
      end
   endtask

   // Reference model: pin history gives the accepted level directly
   logic [W-1:0] hist [HN];
   logic [W-1:0] m_st, m_stq, m_mask, m_cap, m_ren, m_fen;
   logic         m_irq;
   logic [31:0]  exp_q [$];

   function automatic logic [31:0] model_word(input logic [1:0] a);
      logic [31:0] v;
      v = '0;
      case (a)
         2'd0: v[W-1:0] = m_st;
         2'd1: v[W-1:0] = m_mask;
         2'd2: v[W-1:0] = m_cap;
         default: begin
            v[W-1:0] = m_ren;
            v[16 +: W] = m_fen;
         end
      endcase
      return v;
   endfunction

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < HN; i++) hist[i] <= '0;
         m_st <= '0; m_stq <= '0; m_mask <= '0; m_cap <= '0;
         m_ren <= '0; m_fen <= '0; m_irq <= 1'b0;
         exp_q.delete();
      end else begin
         logic [W-1:0] set, clr, cap_n, mask_n, nst;
         if (avs_read) exp_q.push_back(model_word(avs_address));
         set = ((m_st & ~m_stq) & m_ren) | ((~m_st & m_stq) & m_fen);
         clr = (avs_write && avs_address == 2'd2) ? avs_writedata[W-1:0] : '0;
         cap_n = (m_cap & ~clr) | set;
         mask_n = (avs_write && avs_address == 2'd1) ?
                  avs_writedata[W-1:0] : m_mask;
         if (avs_write && avs_address == 2'd3) begin
            m_ren <= avs_writedata[W-1:0];
            m_fen <= avs_writedata[16 +: W];
         end
`ifdef PIO_IN_DEBOUNCE_EN
         // flips when the last D synchronized samples all disagree
         for (int b = 0; b < W; b++) begin
            bit flip;
            flip = 1'b1;
            for (int i = 1; i <= D; i++)
               if (hist[i][b] == m_st[b]) flip = 1'b0;
            nst[b] = flip ? ~m_st[b] : m_st[b];
         end
`else
         nst = hist[1];
`endif
         m_cap <= cap_n;
         m_mask <= mask_n;
         m_irq <= |(cap_n & mask_n);
         m_stq <= m_st;
         m_st <= nst;
         for (int i = HN - 1; i > 0; i--) hist[i] <= hist[i-1];
         hist[0] <= pio_in;
      end
   end

   // Monitor / scoreboard
   always @(negedge clk) begin
      if (!rst) begin
         if (avs_readdatavalid) begin
            if (exp_q.size() == 0) begin
               chk("rdvalid_spurious", 32'd1, 32'd0);
            end else begin
               chk("readdata", avs_readdata, exp_q.pop_front());
            end
         end else if (exp_q.size() != 0) begin
            chk("rdvalid_missing", 32'd0, 32'd1);
            exp_q.delete();
         end
         chk("irq", {31'd0, irq}, {31'd0, m_irq});
         chk("waitrequest", {31'd0, avs_waitrequest}, 32'd0);
      end
   end

   task automatic cyc(input bit rd, input bit wr, input logic [1:0] a,
                      input logic [31:0] d);
      avs_read = rd;
      avs_write = wr;
      avs_address = a;
      avs_writedata = d;
      @(posedge clk);
      #2;
      avs_read = 1'b0;
      avs_write = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(0, 0, 2'd0, 32'd0);
   endtask

   task automatic rd(input logic [1:0] a);
      cyc(1, 0, a, 32'd0);
   endtask

   task automatic wr(input logic [1:0] a, input logic [31:0] d);
      cyc(0, 1, a, d);
   endtask

   initial begin
      int hold;
      int r;
      #2 rst = 1'b1;
      @(posedge clk); #2;
      chk("reset_irq", {31'd0, irq}, 32'd0);
      chk("reset_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
      chk("reset_readdata", avs_readdata, 32'd0);
      rst = 1'b0;

      // 1: read DATA after reset
      rd(2'd0);
      idle(2);

      // 2: rise capture with irq, then W1C
      wr(2'd3, 32'h0000_0001);
      wr(2'd1, 32'h0000_0001);
      pio_in = 3'b001;
      idle(LAT + 2);
      rd(2'd0);
      rd(2'd2);
      wr(2'd2, 32'h0000_0001);
      rd(2'd2);
      idle(2);

      // 3: fall capture on bit 1, W1C of another bit ignored
      wr(2'd3, 32'h0002_0000);
      pio_in = 3'b011;
      idle(LAT + 2);
      pio_in = 3'b001;
      idle(LAT + 2);
      rd(2'd2);
      wr(2'd2, 32'h0000_0001);
      rd(2'd2);
      wr(2'd2, 32'h0000_0002);
      rd(2'd3);

      // 4: short pulse then long hold on bit 2, DATA read every clock
      wr(2'd3, 32'h0004_0004);
      pio_in = 3'b101;
      for (int i = 0; i < 5; i++) rd(2'd0);
      pio_in = 3'b001;
      for (int i = 0; i < LAT + 4; i++) rd(2'd0);
      pio_in = 3'b101;
      for (int i = 0; i < 12; i++) rd(2'd0);
      for (int i = 0; i < LAT + 2; i++) rd(2'd0);
      wr(2'd2, 32'h0000_0007);

      // 5: W1C on bit 0 in the capture cycle of a new rise
      wr(2'd3, 32'h0000_0001);
      wr(2'd1, 32'h0000_0001);
      pio_in = 3'b100;
      idle(LAT + 2);
      pio_in = 3'b101;
      idle(LAT + 2);
      pio_in = 3'b100;
      idle(LAT + 2);
      pio_in = 3'b101;
      idle(LAT);
      wr(2'd2, 32'h0000_0001);
      rd(2'd2);
      idle(2);

      // 6: four back-to-back reads, then reset during a burst
      rd(2'd0); rd(2'd1); rd(2'd2); rd(2'd3);
      idle(2);
      rd(2'd2);
      rd(2'd1);
      chk("burst_valid_pending", {31'd0, avs_readdatavalid}, 32'd1);
      rst = 1'b1;
      #1;
      chk("midrst_rdvalid", {31'd0, avs_readdatavalid}, 32'd0);
      chk("midrst_irq", {31'd0, irq}, 32'd0);
      @(posedge clk); #2;
      rst = 1'b0;
      rd(2'd2);
      rd(2'd3);
      idle(2);

      // Randomized traffic
      hold = 0;
      for (int n = 0; n < 3000; n++) begin
         if (hold == 0) begin
            pio_in = W'($urandom);
            hold = $urandom_range(1, D + 4);
         end
         hold--;
         r = $urandom_range(0, 9);
         if (r <= 3) rd(2'($urandom));
         else if (r == 4) wr(2'd1, $urandom);
         else if (r == 5) wr(2'd3, $urandom);
         else if (r == 6) wr(2'd2, $urandom);
         else if (r == 7) cyc(1, 1, 2'($urandom), $urandom);
         else idle(1);
      end
      idle(LAT + 4);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
